// File: rtl/load_store_unit.sv
// load_store_unit: pipeline-to-bus load/store FSM; define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_next;
    logic access, is_half, is_word, trap, start, capture;
    logic [1:0] off, off_q;
    logic [2:0] funct_q;
    logic [3:0] strb;
    logic [31:0] wdata, shifted, load_val;

    assign access  = MemWriteM | (ResultSrcM == 2'b01);
    assign is_word = Funct3M[1];
    assign is_half = Funct3M[1:0] == 2'b01;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = !rst & access & (state == IDLE) & ((is_half & ALUResultM[0]) | (is_word & |ALUResultM[1:0]));
`else
    assign trap = 1'b0;
`endif
    // Halves ignore addr[0] and words ignore addr[1:0] when they are not trapped
    assign off     = is_word ? 2'b00 : is_half ? {ALUResultM[1], 1'b0} : ALUResultM[1:0];
    assign start   = (state == IDLE) & access & !trap;
    assign strb    = is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001) << off;
    assign wdata   = is_word ? WriteDataM : is_half ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};
    assign capture = dmem_rvalid & !dmem_we & ((state == WAIT) | ((state == REQ) & dmem_ready));
    assign shifted = dmem_rdata >> {off_q, 3'b000};
    assign load_val = funct_q[1] ? shifted :
                      funct_q[0] ? {{16{~funct_q[2] & shifted[15]}}, shifted[15:0]} :
                                   {{24{~funct_q[2] & shifted[7]}}, shifted[7:0]};

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = start ? REQ : IDLE;
            REQ:  state_next = !dmem_ready ? REQ : (dmem_we | dmem_rvalid) ? DONE : WAIT;
            WAIT: state_next = dmem_rvalid ? DONE : WAIT;
            DONE: state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req  = state == REQ;
        StallM    = !rst & access & !trap & (state != DONE);
        MisalignM = trap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_addr  <= '0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= '0;
            dmem_wdata <= '0;
            funct_q    <= '0;
            off_q      <= '0;
            ReadDataM  <= '0;
        end else begin
            if (start) begin
                dmem_addr  <= {ALUResultM[31:2], 2'b00};
                dmem_we    <= MemWriteM;
                dmem_wstrb <= MemWriteM ? strb : 4'b0000;
                dmem_wdata <= wdata;
                funct_q    <= Funct3M;
                off_q      <= off;
            end
            if (capture)
                ReadDataM <= load_val;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random accesses checked against an arithmetic model of lane/extension rules.
module tb_load_store_unit;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic MemWriteM = 1'b0;
    logic [1:0] ResultSrcM = 2'b00;
    logic [2:0] Funct3M = 3'b000;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic StallM, MisalignM, dmem_req, dmem_we;
    logic [31:0] ReadDataM, dmem_addr, dmem_wdata;
    logic [3:0] dmem_wstrb;
    logic dmem_ready = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    int n_assert = 0, n_fail = 0;
    logic [31:0] model_rd = '0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallM(StallM), .ReadDataM(ReadDataM),
        .MisalignM(MisalignM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] mask_of(input int sz);
        return sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        int sz = size_of(f);
        int off = int'(a[1:0]) / sz * sz;
        logic [31:0] mask = mask_of(sz);
        logic [31:0] v = (rd >> (8 * off)) & mask;
        if (!f[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_access(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int rdy_dly, input int rv_dly);
        int sz, off, stalls, reqc, waitc, exp_stalls;
        logic [31:0] mask, exp_wd;
        logic [3:0] exp_strb;
        bit trap, ready_seen, done;
        logic [1:0] rs;
        sz = size_of(f);
        off = int'(a[1:0]) / sz * sz;
        mask = mask_of(sz);
        exp_wd = '0;
        for (int i = 0; i < 4 / sz; i++) exp_wd = exp_wd | ((wd & mask) << (8 * sz * i));
        exp_strb = 4'(((1 << sz) - 1) << off);
        trap = TRAP && (int'(a[1:0]) % sz != 0);
        exp_stalls = trap ? 0 : 1 + rdy_dly + 1 + (we ? 0 : rv_dly);
        MemWriteM = we;
        ResultSrcM = we ? 2'($urandom) : 2'b01;
        Funct3M = f;
        ALUResultM = a;
        WriteDataM = wd;
        dmem_ready = 1'($urandom);
        dmem_rvalid = 1'($urandom);
        dmem_rdata = $urandom;
        #1;
        chk("misalign", 32'(MisalignM), 32'(trap));
        stalls = 0; reqc = 0; waitc = 0; ready_seen = 0; done = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); @(negedge clk);
                dmem_ready = 1'b0;
                dmem_rvalid = 1'b0;
                if (dmem_req) begin
                    chk("addr", dmem_addr, a & ~32'h3);
                    chk("we", 32'(dmem_we), 32'(we));
                    if (we) begin
                        chk("wstrb", 32'(dmem_wstrb), 32'(exp_strb));
                        chk("wdata", dmem_wdata, exp_wd);
                    end
                    dmem_ready = reqc == rdy_dly;
                    reqc++;
                    if (dmem_ready) ready_seen = 1;
                    if (dmem_ready && !we && rv_dly == 0) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = rd;
                    end
                end else if (ready_seen) begin
                    waitc++;
                    if (!we && waitc == rv_dly) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = rd;
                    end
                end
                #1;
            end
            if (StallM) stalls++; else done = 1;
        end
        chk("done_in_budget", 32'(done), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (trap) chk("no_req_on_trap", 32'(dmem_req), 32'd0);
        if (!we && !trap) model_rd = load_model(f, a, rd);
        chk("read_data", ReadDataM, model_rd);
        rs = 2'($urandom);
        MemWriteM = 1'b0;
        ResultSrcM = rs == 2'b01 ? 2'b00 : rs;
        dmem_ready = 1'($urandom);
        dmem_rvalid = 1'($urandom);
        dmem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        chk("idle_stall", 32'(StallM), 32'd0);
        chk("idle_no_req", 32'(dmem_req), 32'd0);
        chk("read_hold", ReadDataM, model_rd);
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(StallM), 32'd0);
        rst = 1'b0;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_misalign", 32'(MisalignM), 32'd0);
        @(negedge clk);
        run_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FFFF, 3, 1);
        chk("lb_sext", ReadDataM, 32'hFFFF_FF80);
        run_access(1'b1, 3'b001, 32'h302, 32'h0000_ABCD, 32'h0, 1, 0);
        run_access(1'b0, 3'b101, 32'h302, 32'h0, 32'hABCD_0000, 0, 2);
        chk("lhu_zext", ReadDataM, 32'h0000_ABCD);
        run_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0, 0);
        run_access(1'b0, 3'b110, 32'h104, 32'h0, 32'h8765_4321, 0, 1);
        // Reset while a load sits in WAIT; a late rvalid must be ignored
        MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h400;
        @(posedge clk); @(negedge clk);
        chk("rw_in_req", 32'(dmem_req), 32'd1);
        dmem_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        dmem_ready = 1'b0;
        chk("rw_in_wait_stall", 32'(StallM), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_stall_during_rst", 32'(StallM), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        ResultSrcM = 2'b00;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        model_rd = '0;
        #1;
        chk("rw_req_dropped", 32'(dmem_req), 32'd0);
        @(posedge clk); @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rw_rdata_zero", ReadDataM, 32'd0);
        chk("rw_idle_req", 32'(dmem_req), 32'd0);
        chk("rw_idle_stall", 32'(StallM), 32'd0);
        for (int n = 0; n < 40; n++)
            run_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
